// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
//   Definitions shared by the classic Wishbone master controller and any block
//   that wants to observe its state:
//     - wb_ctrl_state_t : two-state controller FSM encoding (IDLE, CYCLE)
//     - WB_*_DEF        : default data/address widths and default watchdog limit
// -----------------------------------------------------------------------------
package wishbone_pkg;

  // Default bus geometry.
  localparam int WB_DAT_WIDTH_DEF = 8;
  localparam int WB_ADR_WIDTH_DEF = 16;

  // Default watchdog limit in clock cycles (only used when the watchdog is built in).
  localparam int WB_TIMEOUT_DEF   = 255;

  // Controller state: IDLE waits for a local request, CYCLE holds an open
  // Wishbone classic cycle until the slave acknowledges (or the watchdog fires).
  typedef enum logic {
    IDLE  = 1'b0,
    CYCLE = 1'b1
  } wb_ctrl_state_t;

endpackage : wishbone_pkg

// File: rtl/wishbone_ctrl_classic.sv
// -----------------------------------------------------------------------------
// wishbone_ctrl_classic
//   Single-outstanding Wishbone classic master. A local request (start) is
//   captured in IDLE and turned into one Wishbone cycle; the cycle is held until
//   ack_i, then the controller returns to IDLE with a one-cycle done pulse.
//
// Optional feature (compile-time macro WB_CTRL_TIMEOUT_EN):
//   defined   : a watchdog ends a cycle after TIMEOUT_CYCLES clocks without
//               ack_i, pulsing done and error together; read_data is untouched.
//   undefined : no watchdog, error is tied low, cycles wait forever for ack_i.
//
// Parameters:
//   DAT_WIDTH       data bus width
//   ADR_WIDTH       address bus width
//   TIMEOUT_CYCLES  watchdog limit in clock cycles, 1..65535
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   start        local request, only sampled in IDLE
//   write_en     1 = write cycle, 0 = read cycle
//   addr         local address
//   write_data   local write data
//   read_data    last successfully read word
//   busy         high whenever the controller is not IDLE
//   done         one-cycle completion pulse
//   error        one-cycle timeout pulse, coincident with done
//   cyc_o/stb_o  Wishbone cycle / strobe
//   we_o         Wishbone write enable
//   adr_o        Wishbone address
//   dat_o        Wishbone write data
//   dat_i        Wishbone read data
//   ack_i        Wishbone acknowledge
// -----------------------------------------------------------------------------
module wishbone_ctrl_classic
  import wishbone_pkg::*;
#(
  parameter int DAT_WIDTH      = WB_DAT_WIDTH_DEF,
  parameter int ADR_WIDTH      = WB_ADR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  // Local request side
  input  logic                 start,
  input  logic                 write_en,
  input  logic [ADR_WIDTH-1:0] addr,
  input  logic [DAT_WIDTH-1:0] write_data,
  output logic [DAT_WIDTH-1:0] read_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,

  // Wishbone master side
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic                 ack_i
);

  // Reject an out-of-range watchdog limit at elaboration time.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("wishbone_ctrl_classic: TIMEOUT_CYCLES must be in 1..65535");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_ctrl_state_t         state_q,     state_d;
  logic                   we_q,        we_d;
  logic [ADR_WIDTH-1:0]   adr_q,       adr_d;
  logic [DAT_WIDTH-1:0]   dat_q,       dat_d;
  logic [DAT_WIDTH-1:0]   read_data_q, read_data_d;
  logic                   done_q,      done_d;

`ifdef WB_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of CYCLE clocks already spent without ack.
  // The edge that would bring it to TIMEOUT_CYCLES is the timeout edge, so
  // the comparison is made against the limit minus one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic                   error_q,     error_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
`ifdef WB_CTRL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      error_q     <= error_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
    error_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // ack_i is deliberately not looked at here: a stray ack while idle
        // must not complete anything.
        if (start) begin
          state_d = CYCLE;
          we_d    = write_en;
          adr_d   = addr;
          dat_d   = write_data;
`ifdef WB_CTRL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      CYCLE: begin
        // start is ignored here; the bus qualifiers stay frozen in we_q,
        // adr_q and dat_q until the cycle ends.
        if (ack_i) begin
          // Ack wins over a simultaneous watchdog expiry.
          state_d = IDLE;
          done_d  = 1'b1;
          if (!we_q) begin
            read_data_d = dat_i;
          end
        end
`ifdef WB_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // cyc/stb are decoded straight from the state register so that an
  // asynchronous reset drops them immediately, and so that the IDLE clock
  // following every completion guarantees a gap of at least one clock.
  assign cyc_o     = (state_q == CYCLE);
  assign stb_o     = (state_q == CYCLE);
  assign busy      = (state_q != IDLE);
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign read_data = read_data_q;
  assign done      = done_q;

`ifdef WB_CTRL_TIMEOUT_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule : wishbone_ctrl_classic

// File: doc/wishbone_ctrl_classic.md
WISHBONE_CTRL_CLASSIC -- requirements
Module: wishbone_ctrl_classic

Interface
REQ-001 Parameter DAT_WIDTH, default 8, SHALL set the data bus width in bits.
REQ-002 Parameter ADR_WIDTH, default 16, SHALL set the address bus width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit in clk_i cycles; legal range is 1..65535.
REQ-004 The design has one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_i  in  1  sole clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start  in  1  local request; sampled only in IDLE.
- write_en  in  1  1 selects a write cycle, 0 selects a read cycle.
- addr  in  ADR_WIDTH  local address.
- write_data  in  DAT_WIDTH  local write data.
- read_data  out  DAT_WIDTH  last successfully read word.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle timeout pulse, coincident with done.
- cyc_o, stb_o  out  1 each  Wishbone cycle and strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  ADR_WIDTH  Wishbone address.
- dat_o  out  DAT_WIDTH  Wishbone write data.
- dat_i  in  DAT_WIDTH  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.

Function
REQ-006 The FSM SHALL have two states: IDLE and CYCLE.
REQ-007 In IDLE with start=1 at edge N, the block SHALL latch write_en, addr and write_data into we_o, adr_o and dat_o, and SHALL enter CYCLE with cyc_o=stb_o=1 after edge N.
REQ-008 In CYCLE, cyc_o, stb_o, we_o, adr_o and dat_o SHALL be held stable until the cycle terminates.
REQ-009 At an edge in CYCLE with ack_i=1, the block SHALL drop cyc_o and stb_o, pulse done for one cycle, return to IDLE, and, for reads only, register dat_i into read_data.
REQ-010 The earliest done SHALL occur after edge N+1, when ack_i is already high at that edge; there is no upper bound without the watchdog.
REQ-011 start SHALL be ignored while busy=1; queued requests and errors are not supported.
REQ-012 ack_i SHALL be ignored in IDLE.
REQ-013 Between consecutive cycles, cyc_o SHALL be low for at least one clock; start sampled in the cycle where done=1 SHALL begin the next transaction.
REQ-014 read_data SHALL hold its value across writes, timeouts and idle periods.

Reset
REQ-015 When rst_ni=0, asynchronously: state SHALL be IDLE; cyc_o, stb_o, we_o, done, error and busy SHALL be 0; adr_o, dat_o and read_data SHALL be 0; the watchdog counter SHALL be 0.
REQ-016 Reset asserted during CYCLE SHALL abort the transaction immediately with no done pulse; operation SHALL resume on the first edge after rst_ni rises.

Configuration
REQ-017 Macro WB_CTRL_TIMEOUT_EN SHALL select the watchdog behaviour as follows.
- Defined: a counter SHALL clear on entry to CYCLE and increment each CYCLE clock without ack_i. When it reaches TIMEOUT_CYCLES, the block SHALL drop cyc_o and stb_o, pulse done=error=1 for one cycle, leave read_data unchanged, and return to IDLE. If ack_i=1 on the limit edge, the ack SHALL win and error SHALL be 0.
- Undefined: the counter SHALL be absent, error SHALL be tied to 0, and CYCLE SHALL wait indefinitely for ack_i.

Structure
REQ-018 Shared package wishbone_pkg SHALL hold the state enum wb_ctrl_state_t (IDLE, CYCLE) and the default width constants.
REQ-019 The block SHALL be a single module with no sub-module; the watchdog counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-020 The bench SHALL cover each of the following directed scenarios, stimulus -> required response.
- Write: start with we=1, addr=0x0012, data=0xA5; device acks on the 2nd CYCLE clock -> adr_o=0x0012, dat_o=0xA5, we_o=1 held for 2 clocks, then done=1 for 1 cycle and busy=0.
- Read: start with we=0, addr=0x0034; device returns dat_i=0x5C with ack on the 1st CYCLE clock -> read_data=0x5C, done after edge N+1; a subsequent write leaves read_data at 0x5C.
- Back-to-back: start held high for 3 transactions against an immediate-ack device -> 3 done pulses, cyc_o low for at least 1 clock between each, no missed or duplicated cycle.
- Ignore rules: start pulses during CYCLE and ack_i pulses during IDLE -> no extra transactions and no done.
- Timeout, macro defined, TIMEOUT_CYCLES=4, no ack -> done=error=1 after exactly 4 CYCLE clocks and read_data unchanged; ack on the 4th clock -> error=0. Macro undefined -> cycle persists beyond 1000 clocks with error=0.
- Reset: rst_ni pulsed low mid-CYCLE (asynchronously, between edges) -> cyc_o, stb_o and busy fall immediately with no done; the next start completes normally.
